// File: rtl/cpu_bus_controller.sv
// ---------------------------------------------------------------------------
// cpu_bus_controller
//
// Generates a divided CPU clock from the system clock, decodes the CPU
// address into ROM / VDP / IO / RAM selects, captures read data for the CPU,
// issues single-cycle write strobes, and holds a bank of 8-bit IO output
// registers.
//
// The CPU cycle is driven by a free-running phase counter. Its MSB is
// cpu_clk. The last count of the low phase is the "commit" cycle. In that
// cycle every read or write of the bus cycle takes effect, so cpu_di and the
// IO registers update on the same clk edge on which cpu_clk rises. A
// peripheral can extend the low phase by asserting stretch at that count.
//
// Parameters
//   CPU_DIV_W  cpu_clk period = 2^CPU_DIV_W clk cycles (CPU_DIV_W >= 2)
//   NUM_PORTS  number of 8-bit IO output registers (1..16)
//   IO_BASE    address of IO port 0
//
// Ports
//   clk        system clock, the only clock
//   reset_n    asynchronous active-low reset
//   cpu_addr   CPU address bus
//   cpu_we     CPU write enable (1 = write)
//   cpu_do     CPU write data
//   rom_data   ROM read data
//   ram_data   RAM read data
//   vdp_data   VDP read data
//   stretch    wait request; holds the last low-phase count while high
//   cpu_clk    divided CPU clock
//   cpu_di     registered CPU read data
//   rom_sel    combinational address decode: ROM
//   vdp_sel    combinational address decode: VDP
//   io_sel     combinational address decode: IO ports
//   ram_sel    combinational address decode: RAM
//   ram_we     RAM write strobe, commit cycle only
//   vdp_rd     VDP read level, asserted during the low phase
//   vdp_wr     VDP write strobe, commit cycle only
//   io_ports   IO registers; port n occupies bits [8n+7:8n]
// ---------------------------------------------------------------------------
module cpu_bus_controller #(
  parameter int          CPU_DIV_W = 2,
  parameter int          NUM_PORTS = 4,
  parameter logic [15:0] IO_BASE   = 16'h8400
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            cpu_addr,
  input  logic                   cpu_we,
  input  logic [7:0]             cpu_do,
  input  logic [7:0]             rom_data,
  input  logic [7:0]             ram_data,
  input  logic [7:0]             vdp_data,
  input  logic                   stretch,
  output logic                   cpu_clk,
  output logic [7:0]             cpu_di,
  output logic                   rom_sel,
  output logic                   vdp_sel,
  output logic                   io_sel,
  output logic                   ram_sel,
  output logic                   ram_we,
  output logic                   vdp_rd,
  output logic                   vdp_wr,
  output logic [8*NUM_PORTS-1:0] io_ports
);

  // Last count of the low phase of cpu_clk.
  localparam logic [CPU_DIV_W-1:0] LAST_LOW = CPU_DIV_W'((1 << (CPU_DIV_W - 1)) - 1);

  // One past the highest IO address. It is 17 bits wide so that a port range
  // ending at 16'hFFFF does not wrap.
  localparam logic [16:0] IO_END = {1'b0, IO_BASE} + 17'(NUM_PORTS);

  logic [CPU_DIV_W-1:0] cnt_reg;
  logic [CPU_DIV_W-1:0] cnt_next;
  logic                 at_last_low;
  logic                 commit;
  logic [7:0]           cpu_di_reg;
  logic [15:0]          io_off;
  logic [7:0]           io_rd_data;
  logic [7:0]           rd_data;
  logic                 io_wr;
  logic [7:0]           io_reg [NUM_PORTS];

  // -------------------------------------------------------------------------
  // Phase counter / cpu_clk
  // -------------------------------------------------------------------------
  assign at_last_low = (cnt_reg == LAST_LOW);
  assign commit      = at_last_low && !stretch;

  // stretch has an effect only at LAST_LOW. Holding the counter there keeps
  // commit from firing again, so a stretched cycle still yields one access.
  always_comb begin
    cnt_next = cnt_reg + CPU_DIV_W'(1);
    if (at_last_low && stretch) begin
      cnt_next = cnt_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // The counter is a register, so its MSB is already a glitch-free
  // registered clock.
  assign cpu_clk = cnt_reg[CPU_DIV_W-1];

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  assign io_off  = cpu_addr - IO_BASE;
  assign rom_sel = (cpu_addr[15:13] == 3'b111);
  assign vdp_sel = (cpu_addr[15:8] == 8'hC0);
  assign io_sel  = (cpu_addr >= IO_BASE) && ({1'b0, cpu_addr} < IO_END);
  assign ram_sel = !(rom_sel || vdp_sel || io_sel);

  // -------------------------------------------------------------------------
  // Strobes
  // -------------------------------------------------------------------------
  // The counter is 0 during reset, so commit and both strobes are low then.
  assign ram_we = commit && cpu_we && ram_sel;
  assign vdp_wr = commit && cpu_we && vdp_sel;
  assign vdp_rd = !cpu_clk && !cpu_we && vdp_sel;
  assign io_wr  = commit && cpu_we && io_sel;

  // -------------------------------------------------------------------------
  // IO output registers
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_io_port
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          io_reg[gi] <= 8'h00;
        end else if (io_wr && (io_off == 16'(gi))) begin
          io_reg[gi] <= cpu_do;
        end
      end
      assign io_ports[8*gi +: 8] = io_reg[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  always_comb begin
    io_rd_data = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (io_off == 16'(i)) begin
        io_rd_data = io_reg[i];
      end
    end
  end

  always_comb begin
    if (rom_sel) begin
      rd_data = rom_data;
    end else if (vdp_sel) begin
      rd_data = vdp_data;
    end else if (io_sel) begin
      rd_data = io_rd_data;
    end else begin
      rd_data = ram_data;
    end
  end

  // The load happens on the same edge on which cpu_clk rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_di_reg <= 8'h00;
    end else if (commit && !cpu_we) begin
      cpu_di_reg <= rd_data;
    end
  end

  assign cpu_di = cpu_di_reg;

endmodule

// File: tb/tb_cpu_bus_controller.sv
// ---------------------------------------------------------------------------
// Testbench for cpu_bus_controller (CPU_DIV_W=2, NUM_PORTS=4, IO_BASE=8400).
// Each bus transaction is driven as one whole CPU cycle. The expected value
// of every output in every clk of that cycle comes from the cycle rules:
// the low phase is HALF + stretch clks long, the last low clk is the commit
// cycle, and the high phase is HALF clks. Stretch noise is injected where it
// must be ignored.
// ---------------------------------------------------------------------------
module tb_cpu_bus_controller;

  localparam int          W       = 2;
  localparam int          NP      = 4;
  localparam logic [15:0] IO_BASE = 16'h8400;
  localparam int          HALF    = 1 << (W - 1);

  logic          clk;
  logic          reset_n;
  logic [15:0]   cpu_addr;
  logic          cpu_we;
  logic [7:0]    cpu_do;
  logic [7:0]    rom_data;
  logic [7:0]    ram_data;
  logic [7:0]    vdp_data;
  logic          stretch;
  logic          cpu_clk;
  logic [7:0]    cpu_di;
  logic          rom_sel;
  logic          vdp_sel;
  logic          io_sel;
  logic          ram_sel;
  logic          ram_we;
  logic          vdp_rd;
  logic          vdp_wr;
  logic [8*NP-1:0] io_ports;

  int n_total;
  int n_bad;
  int n_txn;

  logic [7:0] m_ports [NP];
  logic [7:0] m_di;

  cpu_bus_controller #(
    .CPU_DIV_W (W),
    .NUM_PORTS (NP),
    .IO_BASE   (IO_BASE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_addr (cpu_addr),
    .cpu_we   (cpu_we),
    .cpu_do   (cpu_do),
    .rom_data (rom_data),
    .ram_data (ram_data),
    .vdp_data (vdp_data),
    .stretch  (stretch),
    .cpu_clk  (cpu_clk),
    .cpu_di   (cpu_di),
    .rom_sel  (rom_sel),
    .vdp_sel  (vdp_sel),
    .io_sel   (io_sel),
    .ram_sel  (ram_sel),
    .ram_we   (ram_we),
    .vdp_rd   (vdp_rd),
    .vdp_wr   (vdp_wr),
    .io_ports (io_ports)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cpu_clk"}, 32'(cpu_clk), 32'd0);
    check_val({tag, "_cpu_di"}, 32'(cpu_di), 32'h00);
    check_val({tag, "_io_ports"}, 32'(io_ports), 32'h0);
    check_val({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check_val({tag, "_vdp_wr"}, 32'(vdp_wr), 32'd0);
  endtask

  // Runs one full CPU cycle. It must be entered at a falling clk edge that
  // starts a cycle, and it returns at the falling edge that starts the next
  // one. The caller sets rom_data, ram_data and vdp_data beforehand.
  task automatic do_txn(input logic [15:0] a, input logic we, input logic [7:0] d,
                        input int nst, input bit noise);
    int         len_low;
    int         pidx;
    bit         is_rom, is_vdp, is_io, is_ram;
    logic [7:0] rd;
    logic [7:0] di_after;
    bit         low;

    len_low = HALF + nst;
    is_rom  = (a >= 16'hE000);
    is_vdp  = (a >= 16'hC000) && (a < 16'hC100);
    pidx    = int'(a) - int'(IO_BASE);
    is_io   = (pidx >= 0) && (pidx < NP);
    is_ram  = !(is_rom || is_vdp || is_io);

    if (is_rom)      rd = rom_data;
    else if (is_vdp) rd = vdp_data;
    else if (is_io)  rd = m_ports[pidx];
    else             rd = ram_data;
    di_after = we ? m_di : rd;

    cpu_addr = a;
    cpu_we   = we;
    cpu_do   = d;

    for (int i = 0; i < len_low + HALF; i++) begin
      if (i >= HALF - 1 && i < len_low - 1)
        stretch = 1'b1;
      else if (i == len_low - 1)
        stretch = 1'b0;
      else
        stretch = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      low = (i < len_low);
      check_val("cpu_clk", 32'(cpu_clk), 32'(!low));
      check_val("ram_we", 32'(ram_we), 32'(i == len_low - 1 && we && is_ram));
      check_val("vdp_wr", 32'(vdp_wr), 32'(i == len_low - 1 && we && is_vdp));
      check_val("vdp_rd", 32'(vdp_rd), 32'(low && !we && is_vdp));
      check_val("cpu_di", 32'(cpu_di), 32'(low ? m_di : di_after));
      if (i == 0) begin
        check_val("rom_sel", 32'(rom_sel), 32'(is_rom));
        check_val("vdp_sel", 32'(vdp_sel), 32'(is_vdp));
        check_val("io_sel", 32'(io_sel), 32'(is_io));
        check_val("ram_sel", 32'(ram_sel), 32'(is_ram));
      end
      if (i == len_low - 1 && we && is_io)
        check_val("io_port_pre", 32'(io_ports[8*pidx +: 8]), 32'(m_ports[pidx]));
      @(negedge clk);
    end

    m_di = di_after;
    if (we && is_io) m_ports[pidx] = d;
    #1;
    for (int p = 0; p < NP; p++)
      check_val("io_port", 32'(io_ports[8*p +: 8]), 32'(m_ports[p]));
    n_txn++;
    $display("txn %0d addr=%h we=%b do=%h stretch=%0d cpu_di=%h ports=%h",
             n_txn, a, we, d, nst, cpu_di, io_ports);
  endtask

  task automatic clear_model();
    m_di = 8'h00;
    for (int p = 0; p < NP; p++) m_ports[p] = 8'h00;
  endtask

  initial begin
    logic [15:0] a;
    int          cat;

    n_total  = 0;
    n_bad    = 0;
    n_txn    = 0;
    reset_n  = 1'b0;
    cpu_addr = 16'h0000;
    cpu_we   = 1'b0;
    cpu_do   = 8'h00;
    rom_data = 8'h00;
    ram_data = 8'h00;
    vdp_data = 8'h00;
    stretch  = 1'b0;
    clear_model();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Plain cycles: cpu_clk pattern 0,0,1,1.
    ram_data = 8'h33;
    do_txn(16'h1000, 1'b0, 8'h00, 0, 1'b0);
    do_txn(16'h1000, 1'b0, 8'h00, 0, 1'b0);

    // IO write followed by read-back.
    do_txn(16'h8402, 1'b1, 8'h5A, 0, 1'b0);
    do_txn(16'h8402, 1'b0, 8'h00, 0, 1'b0);

    // ROM and RAM reads.
    rom_data = 8'hA9;
    ram_data = 8'h11;
    do_txn(16'hE123, 1'b0, 8'h00, 0, 1'b0);
    do_txn(16'h1000, 1'b0, 8'h00, 0, 1'b0);

    // RAM write with a 3-clk stretch.
    do_txn(16'h1000, 1'b1, 8'h77, 3, 1'b0);

    // ROM write is dropped; VDP write and read.
    vdp_data = 8'h6C;
    do_txn(16'hE000, 1'b1, 8'h12, 0, 1'b0);
    do_txn(16'hC001, 1'b1, 8'h34, 0, 1'b0);
    do_txn(16'hC001, 1'b0, 8'h00, 0, 1'b0);

    // Reset in the middle of an IO write to 8400, with the counter at 1.
    cpu_addr = 16'h8400;
    cpu_we   = 1'b1;
    cpu_do   = 8'hC3;
    stretch  = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("hold_reset");
    reset_n = 1'b1;
    clear_model();
    do_txn(16'h8400, 1'b0, 8'h00, 0, 1'b0);

    // Randomized traffic with stretch and stretch noise.
    for (int t = 0; t < 200; t++) begin
      cat = $urandom_range(0, 5);
      case (cat)
        0:       a = 16'hE000 + 16'($urandom_range(0, 16'h1FFF));
        1:       a = 16'hC000 + 16'($urandom_range(0, 255));
        2, 3:    a = IO_BASE + 16'($urandom_range(0, NP - 1));
        4:       a = ($urandom_range(0, 1) == 0) ? (IO_BASE - 16'd1) : (IO_BASE + 16'(NP));
        default: a = 16'($urandom_range(0, 16'hBFFF));
      endcase
      rom_data = 8'($urandom);
      ram_data = 8'($urandom);
      vdp_data = 8'($urandom);
      do_txn(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 4), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
